// File: rtl/axi_addr_gen_2d.sv
// 2D DMA burst-request generator: splits rows into AXI bursts at MAX_BURST and 4 KiB boundaries.
// Optional macro SA_ADDR_GEN_ROW_LAST_EN adds the req_row_last output.
module axi_addr_gen_2d #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned BYTES_PER_BEAT = 16,
    parameter int unsigned MAX_BURST      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       row_bytes,
    input  logic [15:0]       num_rows,
    input  logic [31:0]       stride_bytes,
    output logic              busy,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [ADDR_W-1:0] req_addr,
    output logic [7:0]        req_len,
    output logic              req_last,
    output logic              done,
    output logic              err
`ifdef SA_ADDR_GEN_ROW_LAST_EN
    ,
    output logic              req_row_last
`endif
);

    localparam int unsigned LOG2_BPB = $clog2(BYTES_PER_BEAT);
    localparam int unsigned RB_W     = 32 - LOG2_BPB;

    typedef enum logic [1:0] {IDLE, CALC, ISSUE, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] row_start_q, row_start_d;
    logic [31:0]       stride_q, stride_d;
    logic [RB_W-1:0]   row_beats_q, row_beats_d;
    logic [RB_W-1:0]   row_left_q, row_left_d;
    logic [15:0]       rows_left_q, rows_left_d;
    logic [8:0]        len_q, len_d;
    logic              row_end_q, row_end_d;
    logic              busy_d, req_valid_d, req_last_d, done_d, err_d;
    logic [ADDR_W-1:0] req_addr_d;
    logic [7:0]        req_len_d;

    logic              misaligned;
    logic              empty_cmd;
    logic [12:0]       beats_4k;
    logic [31:0]       len_c;
    logic [ADDR_W-1:0] next_row_start;

    // Burst sizing: smallest of row remainder, MAX_BURST and distance to the next 4 KiB page
    always_comb begin
        beats_4k = 13'((13'd4096 - {1'b0, cur_addr_q[11:0]}) >> LOG2_BPB);
        len_c    = 32'(row_left_q);
        if (32'(MAX_BURST) < len_c) len_c = 32'(MAX_BURST);
        if (32'(beats_4k) < len_c)  len_c = 32'(beats_4k);
        misaligned = (base_addr[LOG2_BPB-1:0] != '0) ||
                     (row_bytes[LOG2_BPB-1:0] != '0) ||
                     (stride_bytes[LOG2_BPB-1:0] != '0);
        empty_cmd      = (row_bytes == 32'd0) || (num_rows == 16'd0);
        next_row_start = row_start_q + ADDR_W'(stride_q);
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        row_start_d = row_start_q;
        stride_d    = stride_q;
        row_beats_d = row_beats_q;
        row_left_d  = row_left_q;
        rows_left_d = rows_left_q;
        len_d       = len_q;
        row_end_d   = row_end_q;
        busy_d      = busy;
        req_valid_d = req_valid;
        req_addr_d  = req_addr;
        req_len_d   = req_len;
        req_last_d  = req_last;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cur_addr_d  = base_addr;
                    row_start_d = base_addr;
                    stride_d    = stride_bytes;
                    row_beats_d = RB_W'(row_bytes >> LOG2_BPB);
                    row_left_d  = RB_W'(row_bytes >> LOG2_BPB);
                    rows_left_d = num_rows;
                    if (misaligned) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else if (empty_cmd) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                len_d       = 9'(len_c);
                row_end_d   = (len_c == 32'(row_left_q));
                req_addr_d  = cur_addr_q;
                req_len_d   = 8'(len_c - 32'd1);
                req_last_d  = (len_c == 32'(row_left_q)) && (rows_left_q == 16'd1);
                req_valid_d = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    cur_addr_d  = cur_addr_q + (ADDR_W'(len_q) << LOG2_BPB);
                    row_left_d  = row_left_q - RB_W'(len_q);
                    if (row_end_q) begin
                        row_start_d = next_row_start;
                        cur_addr_d  = next_row_start;
                        row_left_d  = row_beats_q;
                        rows_left_d = rows_left_q - 16'd1;
                    end
                    if (req_last) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            row_start_q <= '0;
            stride_q    <= '0;
            row_beats_q <= '0;
            row_left_q  <= '0;
            rows_left_q <= '0;
            len_q       <= '0;
            row_end_q   <= 1'b0;
            busy        <= 1'b0;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            req_len     <= '0;
            req_last    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            row_start_q <= row_start_d;
            stride_q    <= stride_d;
            row_beats_q <= row_beats_d;
            row_left_q  <= row_left_d;
            rows_left_q <= rows_left_d;
            len_q       <= len_d;
            row_end_q   <= row_end_d;
            busy        <= busy_d;
            req_valid   <= req_valid_d;
            req_addr    <= req_addr_d;
            req_len     <= req_len_d;
            req_last    <= req_last_d;
            done        <= done_d;
            err         <= err_d;
        end
    end

`ifdef SA_ADDR_GEN_ROW_LAST_EN
    // Row-end flag is captured in CALC alongside the request, so it is already held with it
    assign req_row_last = row_end_q;
`endif

endmodule

// File: doc/axi_addr_gen_2d.md
Name: axi_addr_gen_2d

Overview:
- Functional, parametrised successor to the DMA burst-request generator.
- Accepts one 2D transfer command: `num_rows` rows of `row_bytes` each, with row starts `stride_bytes` apart.
- Emits a stream of AXI-legal burst requests (address + beats-1) over a valid/ready handshake.
- Splits bursts at `MAX_BURST` and at 4 KiB boundaries; sits between the DMA command front-end and the AR/AW channel drivers.

Parameters:
- ADDR_W, AXI_ADDR_WIDTH, byte-address width.
- BYTES_PER_BEAT, AXI_DATA_WIDTH/8, bytes per data beat; power of two, 4..128.
- MAX_BURST, 16, maximum beats per burst; 1..256.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first row start address (byte).
- row_bytes  in  32  bytes per row.
- num_rows  in  16  row count.
- stride_bytes  in  32  row-start-to-row-start distance; 0 is legal (rows repeat the address).
- busy  out  1  high from command acceptance until done.
- req_valid  out  1  burst request valid.
- req_ready  in  1  downstream accept.
- req_addr  out  ADDR_W  burst start address.
- req_len  out  8  beats-1.
- req_last  out  1  final burst of the command.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done on a rejected command.
- req_row_last  out  1  last burst of the current row; present only with SA_ADDR_GEN_ROW_LAST_EN.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous, active-high. All state returns to IDLE and all outputs to 0 (including `req_row_last` when present); this applies mid-transfer too, with no done pulse on abort.
- States: IDLE, CALC, ISSUE, FIN.
- IDLE, `start`=1 (cycle T):
  - Latch `base_addr`, `row_bytes`, `num_rows`, `stride_bytes`.
  - `busy`=1 from T+1.
  - Enter CALC.
- Rejection: if `base_addr`, `row_bytes` or `stride_bytes` is not a multiple of `BYTES_PER_BEAT`, go to FIN with `err` set. Then `done`=`err`=1 at T+1, `busy` stays 0, no requests issued.
- Empty command: `row_bytes`==0 or `num_rows`==0 is not an error. `done`=1 at T+1, `err`=0, no requests.
- CALC (1 cycle):
  - `len_beats` = min(`row_beats_left`, `MAX_BURST`, `beats_to_4k`).
  - `beats_to_4k` = (4096 − `cur_addr[11:0]`) / `BYTES_PER_BEAT`.
  - `row_beats_left` initialised to `row_bytes` >> log2(`BYTES_PER_BEAT`) at each row start.
  - Register `req_addr`=`cur_addr`, `req_len`=`len_beats`−1.
  - `req_last`=1 iff this burst empties the row and it is the final row.
  - Go to ISSUE.
- ISSUE:
  - `req_valid`=1; `req_addr`, `req_len` and `req_last` are held stable while `req_ready`=0.
  - On handshake:
    - `cur_addr` += `len_beats`·`BYTES_PER_BEAT`.
    - `row_beats_left` −= `len_beats`.
    - If the row is exhausted: `row_start` += `stride_bytes`, `cur_addr`=new `row_start`, rows_left −1.
    - Then CALC, or FIN if it was the last burst.
  - `req_valid` drops the cycle after the handshake (one bubble per burst).
  - Latency: first `req_valid` at T+2; next `req_valid` two cycles after each handshake.
- FIN: `done`=1 (plus `err` if rejecting) for one cycle, `busy`=0, return to IDLE. `done` follows the final handshake by exactly 1 cycle.
- Arithmetic: address sums are modulo 2^`ADDR_W` (wrap, no error). Bursts never cross a 4 KiB boundary.
- `start` while not IDLE is ignored.
- `start` coincident with `done` (FIN) is ignored; the earliest accepted `start` is the cycle after `done`.

Optional Feature:
- Macro: SA_ADDR_GEN_ROW_LAST_EN.
- With it: port `req_row_last` exists; 1 on the burst that exhausts the current row, registered in CALC and held with the request.
- Without it: port and logic are absent; `req_last` is unchanged.

Test Plan (`BYTES_PER_BEAT`=16, `MAX_BURST`=16):
- Single row, split by `MAX_BURST`: base 0x1000, row 512, rows 1, ready=1 → requests (0x1000, len 15, last 0), (0x1100, len 15, last 1); `done` 1 cycle after the 2nd handshake.
- 4K split: base 0x0FC0, row 256, rows 1 → (0x0FC0, len 3), (0x1000, len 11, last 1).
- 2D stride: base 0x2000, row 64, rows 3, stride 0x400 → (0x2000, 3), (0x2400, 3), (0x2800, 3, last 1); with ROW_LAST_EN, `req_row_last`=1 on all three.
- Back-pressure: first case with `req_ready` low 5 cycles → `req_valid`/`req_addr`/`req_len` stable for those cycles, no duplicate or lost burst.
- Reject/empty:
  - base 0x1008 → `done`=`err`=1 at T+1, `req_valid` never 1.
  - rows 0 → `done`=1, `err`=0 at T+1.
- Reset mid-op: `rst` during ISSUE of the 2D case → next cycle `req_valid`=`busy`=`done`=0; a fresh command then runs correctly from its own base.
